// File: rtl/rdi_sb_msg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rdi_sb_msg_arbiter_if
//  Description : Handshake bundle between the RDI bring-up blocks, the
//                sideband message arbiter and the sideband serializer.
//                Signal directions are named from the arbiter's point of view.
//  Ports       : i_tx_req_msg/valid  - state request from bring-up TX
//                i_rx_rsp_msg/valid  - state response from bring-up RX
//                o_sb_msg/valid      - message offered to the serializer
//                i_sb_ready/done     - serializer accept / finish pulses
//                o_tx_req_done       - request transmitted pulse
//                o_rx_rsp_done       - response transmitted pulse
//                o_rx_busy           - request pending or in flight
//                o_timeout           - in-flight message dropped pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface rdi_sb_msg_arbiter_if;
    logic [3:0] i_tx_req_msg;
    logic       i_tx_req_valid;
    logic [3:0] i_rx_rsp_msg;
    logic       i_rx_rsp_valid;
    logic [3:0] o_sb_msg;
    logic       o_sb_msg_valid;
    logic       i_sb_ready;
    logic       i_sb_done;
    logic       o_tx_req_done;
    logic       o_rx_rsp_done;
    logic       o_rx_busy;
    logic       o_timeout;

    // The arbiter itself.
    modport slave (
        input  i_tx_req_msg, i_tx_req_valid, i_rx_rsp_msg, i_rx_rsp_valid,
        input  i_sb_ready, i_sb_done,
        output o_sb_msg, o_sb_msg_valid, o_tx_req_done, o_rx_rsp_done,
        output o_rx_busy, o_timeout
    );

    // The surrounding logic (bring-up blocks plus serializer).
    modport master (
        output i_tx_req_msg, i_tx_req_valid, i_rx_rsp_msg, i_rx_rsp_valid,
        output i_sb_ready, i_sb_done,
        input  o_sb_msg, o_sb_msg_valid, o_tx_req_done, o_rx_rsp_done,
        input  o_rx_busy, o_timeout
    );
endinterface
`default_nettype wire

// File: rtl/rdi_sb_msg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rdi_sb_msg_arbiter
//  Description : Captures RDI state requests (bring-up TX) and state
//                responses (bring-up RX) into one-deep pending slots and
//                serializes them one at a time onto the sideband message
//                port. Responses have fixed priority. Every transmission is
//                guarded by a timeout counter.
//  Ports       : lclk     - local clock
//                sys_rst  - asynchronous active-low reset
//                sb       - rdi_sb_msg_arbiter_if.slave handshake bundle
//  Parameters  : TIMEOUT_CYCLES - cycles allowed in SEND+WAIT_DONE (1..255)
//  Revision    : 1.0 - initial release
// ============================================================================
module rdi_sb_msg_arbiter #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  wire logic            lclk,
    input  wire logic            sys_rst,
    rdi_sb_msg_arbiter_if.slave  sb
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_COMPLETE  = 2'd3
    } state_t;

    // Counter value seen on the cycle the limit is reached.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic       r_sel_rsp;      // 1: response owns the sideband, 0: request
    logic [7:0] r_cnt;

    logic       r_req_pend, r_rsp_pend;
    logic [3:0] r_req_msg,  r_rsp_msg;
    logic       r_req_vq,   r_rsp_vq;

    logic [3:0] r_sb_msg;
    logic       r_sb_msg_valid;
    logic       r_tx_done;
    logic       r_rx_done;
    logic       r_busy;
    logic       r_timeout;

    logic w_active, w_in_flight, w_finish;
    logic w_req_selected, w_rsp_selected;
    logic w_complete, w_timeout;
    logic w_req_load, w_rsp_load;
    logic w_req_cancel, w_rsp_cancel;
    logic w_req_drop, w_rsp_drop;
    logic w_req_pend_nxt, w_rsp_pend_nxt;
    logic w_req_eligible, w_rsp_eligible;
    logic w_busy_nxt;

    assign w_active       = (r_state != ST_IDLE);
    assign w_in_flight    = (r_state == ST_SEND) || (r_state == ST_WAIT_DONE);
    assign w_finish       = (r_state == ST_COMPLETE);
    assign w_req_selected = w_active && !r_sel_rsp;
    assign w_rsp_selected = w_active &&  r_sel_rsp;

    // Done only counts where it can actually finish the transfer; a done
    // pulse in SEND without ready is ignored like any stray pulse.
    assign w_complete = ((r_state == ST_SEND) && sb.i_sb_ready && sb.i_sb_done) ||
                        ((r_state == ST_WAIT_DONE) && sb.i_sb_done);
    assign w_timeout  = w_in_flight && (r_cnt == c_TIMEOUT_LAST) && !w_complete;

    // Capture on a rising valid edge with a legal message into an empty slot.
    assign w_req_load = sb.i_tx_req_valid && !r_req_vq &&
                        (sb.i_tx_req_msg != 4'd0) && !r_req_pend;
    assign w_rsp_load = sb.i_rx_rsp_valid && !r_rsp_vq &&
                        (sb.i_rx_rsp_msg != 4'd0) && !r_rsp_pend;

    // A source withdrawing its valid cancels its message unless it already
    // owns the sideband.
    assign w_req_cancel = r_req_pend && !sb.i_tx_req_valid && !w_req_selected;
    assign w_rsp_cancel = r_rsp_pend && !sb.i_rx_rsp_valid && !w_rsp_selected;

    assign w_req_drop = w_req_selected && (w_finish || w_timeout);
    assign w_rsp_drop = w_rsp_selected && (w_finish || w_timeout);

    assign w_req_pend_nxt = (w_req_cancel || w_req_drop) ? 1'b0 : (r_req_pend || w_req_load);
    assign w_rsp_pend_nxt = (w_rsp_cancel || w_rsp_drop) ? 1'b0 : (r_rsp_pend || w_rsp_load);

    // A slot being cancelled this cycle must not win arbitration.
    assign w_req_eligible = r_req_pend && sb.i_tx_req_valid;
    assign w_rsp_eligible = r_rsp_pend && sb.i_rx_rsp_valid;

    assign w_busy_nxt = w_req_pend_nxt || (w_req_selected && !(w_finish || w_timeout));

    always_ff @(posedge lclk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state        <= ST_IDLE;
            r_sel_rsp      <= 1'b0;
            r_cnt          <= 8'd0;
            r_req_pend     <= 1'b0;
            r_rsp_pend     <= 1'b0;
            r_req_msg      <= 4'd0;
            r_rsp_msg      <= 4'd0;
            r_req_vq       <= 1'b0;
            r_rsp_vq       <= 1'b0;
            r_sb_msg       <= 4'd0;
            r_sb_msg_valid <= 1'b0;
            r_tx_done      <= 1'b0;
            r_rx_done      <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_req_vq   <= sb.i_tx_req_valid;
            r_rsp_vq   <= sb.i_rx_rsp_valid;
            r_req_pend <= w_req_pend_nxt;
            r_rsp_pend <= w_rsp_pend_nxt;
            if (w_req_load) r_req_msg <= sb.i_tx_req_msg;
            if (w_rsp_load) r_rsp_msg <= sb.i_rx_rsp_msg;

            r_busy    <= w_busy_nxt;
            r_tx_done <= 1'b0;
            r_rx_done <= 1'b0;
            r_timeout <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rsp_eligible) begin
                        r_sel_rsp      <= 1'b1;
                        r_sb_msg       <= r_rsp_msg;
                        r_sb_msg_valid <= 1'b1;
                        r_cnt          <= 8'd0;
                        r_state        <= ST_SEND;
                    end else if (w_req_eligible) begin
                        r_sel_rsp      <= 1'b0;
                        r_sb_msg       <= r_req_msg;
                        r_sb_msg_valid <= 1'b1;
                        r_cnt          <= 8'd0;
                        r_state        <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_complete) begin
                        r_sb_msg_valid <= 1'b0;
                        r_state        <= ST_COMPLETE;
                    end else if (w_timeout) begin
                        r_sb_msg_valid <= 1'b0;
                        r_timeout      <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else if (sb.i_sb_ready) begin
                        r_sb_msg_valid <= 1'b0;
                        r_state        <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_complete) begin
                        r_state <= ST_COMPLETE;
                    end else if (w_timeout) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_COMPLETE: begin
                    r_tx_done <= !r_sel_rsp;
                    r_rx_done <=  r_sel_rsp;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sb.o_sb_msg       = r_sb_msg;
    assign sb.o_sb_msg_valid = r_sb_msg_valid;
    assign sb.o_tx_req_done  = r_tx_done;
    assign sb.o_rx_rsp_done  = r_rx_done;
    assign sb.o_rx_busy      = r_busy;
    assign sb.o_timeout      = r_timeout;

endmodule
`default_nettype wire

// File: doc/rdi_sb_msg_arbiter.md
# rdi_sb_msg_arbiter

Sideband message arbiter between the RDI bring-up handshake blocks and the sideband serializer. It captures RDI state-request messages from the bring-up TX side and state-response messages from the bring-up RX side, then serializes them one at a time onto a single sideband message port. It returns per-source completion pulses and a busy flag consumed by the bring-up RX stage. A timeout counter guards every transmission.

## Interface
- TIMEOUT_CYCLES, 200: max cycles a message may spend in SEND+WAIT_DONE before it is dropped; 1..255
- lclk  in  1  local clock
- sys_rst  in  1  asynchronous, active-low reset
- i_tx_req_msg  in  4  request encoding (1..7) from bring-up TX
- i_tx_req_valid  in  1  level; request present
- i_rx_rsp_msg  in  4  response encoding (8..15) from bring-up RX
- i_rx_rsp_valid  in  1  level; response present
- o_sb_msg  out  4  message to serializer
- o_sb_msg_valid  out  1  message offered; held until accepted
- i_sb_ready  in  1  serializer accepts offered message (1-cycle pulse)
- i_sb_done  in  1  serializer finished transmitting (1-cycle pulse)
- o_tx_req_done  out  1  1-cycle pulse; request transmitted
- o_rx_rsp_done  out  1  1-cycle pulse; response transmitted (drives bring-up RX done input)
- o_rx_busy  out  1  request pending or in flight (drives bring-up RX busy input)
- o_timeout  out  1  1-cycle pulse; in-flight message dropped

## Operation
- Capture: each source has a pending slot (flag + 4-bit msg) and a registered copy of its valid for edge detection. A rising edge of valid with msg != 0 and slot empty loads the slot. msg == 0, a held-high valid, or a rising edge while the slot is full is ignored.
- Cancel: if a source valid is sampled low while its slot is pending and not selected, the slot clears. Once selected, the message completes or times out regardless of valid.
- FSM states: IDLE, SEND, WAIT_DONE, COMPLETE.
  - IDLE: response slot pending -> select response; else request slot pending -> select request; go SEND. Response has fixed priority.
  - SEND: o_sb_msg_valid=1, o_sb_msg=selected msg. i_sb_ready -> WAIT_DONE. i_sb_ready and i_sb_done in the same cycle -> COMPLETE.
  - WAIT_DONE: i_sb_done -> COMPLETE.
  - COMPLETE: pulse the selected source's done output, clear its slot, go IDLE.
- Timeout: an 8-bit counter clears on entering SEND and increments each cycle in SEND/WAIT_DONE. On reaching TIMEOUT_CYCLES: pulse o_timeout, clear the selected slot, no done pulse, go IDLE. If i_sb_done arrives in the same cycle, done wins and there is no timeout.
- o_rx_busy = request slot pending OR (state != IDLE AND selected == request).
- i_sb_ready/i_sb_done outside SEND/WAIT_DONE are ignored.

## Timing
- Reset values: o_sb_msg=0, o_sb_msg_valid=0, o_tx_req_done=0, o_rx_rsp_done=0, o_rx_busy=0, o_timeout=0. FSM=IDLE, slots empty, counter=0, valid history=0.
- All outputs are registered.
- Valid rising edge sampled at edge k -> slot set after k -> FSM in SEND after k+1 -> o_sb_msg_valid high after k+1.
- o_sb_msg is stable while o_sb_msg_valid=1. Valid drops the cycle after i_sb_ready is sampled.
- i_sb_done sampled at edge m -> COMPLETE after m -> done pulse high for exactly the cycle after m+1. The next message is offered no earlier than edge m+3.
- o_rx_busy falls in the same cycle the request done pulse is asserted.
- Reset mid-operation clears everything immediately; no done or timeout pulses are issued.

## Test plan
- Single response: i_rx_rsp_msg=14, valid rises at edge 10 -> o_sb_msg=14 with valid from edge 12. ready at 14, done at 17 -> o_rx_rsp_done high one cycle after edge 18, o_sb_msg_valid low after 15.
- Simultaneous capture: request 6 and response 8 rise on the same edge -> 8 sent first, then 6. o_rx_busy high from capture until the request done pulse.
- Timeout: TIMEOUT_CYCLES=5, no ready -> o_timeout pulses 5 cycles after entering SEND, no done pulse, slot cleared. A new valid edge is then accepted.
- Cancel / illegal: request valid rises then drops while a response is in flight -> request never sent. msg=0 with valid rising -> ignored.
- Same-cycle ready+done in SEND -> direct COMPLETE, single done pulse.
- Reset asserted in WAIT_DONE -> all outputs 0 immediately. After release, nothing is sent until a new rising valid edge.
